// File: rtl/line_follow_ctrl_p.sv
// Line-follower motor controller: classifies three LFA samples into black/white,
// steers the two H-bridges while following, debounces node detection, executes a
// commanded turn with a timeout, and searches for the line when it is lost.
// Ports:
//   clk_3125KHz, rst          - single clock, async active-high reset
//   start                     - level; low forces IDLE
//   left/middle/right         - ADC_W-bit sensor samples, qualified by sample_valid
//   turn_cmd/turn_valid       - 0 straight, 1 right, 2 U-turn, 3 left; accepted while turn_req
//   m1_a/m1_b/m2_a/m2_b       - H-bridge direction pins (a=1,b=0 forward)
//   dc1/dc2                   - left/right duty cycles
//   node_flag/node_pulse      - in NODE or TURN / one-clock pulse on node entry
//   turn_req/turn_done        - awaiting a command / one-clock pulse on TURN exit
//   timeout_err               - sticky turn timeout
module line_follow_ctrl_p #(
  parameter int unsigned ADC_W       = 12,
  parameter int unsigned DUTY_W      = 5,
  parameter int unsigned TH_BLACK    = 1000,
  parameter int unsigned TH_WHITE    = 300,
  parameter int unsigned NODE_DEB    = 4,
  parameter int unsigned TURN_MAX    = 4095,
  parameter int unsigned DUTY_FWD    = 18,
  parameter int unsigned DUTY_HI     = 20,
  parameter int unsigned DUTY_LO     = 10,
  parameter int unsigned DUTY_TURN   = 18,
  parameter int unsigned DUTY_SEARCH = 12
) (
  input  logic              clk_3125KHz,
  input  logic              rst,
  input  logic              start,
  input  logic [ADC_W-1:0]  left,
  input  logic [ADC_W-1:0]  middle,
  input  logic [ADC_W-1:0]  right,
  input  logic              sample_valid,
  input  logic [1:0]        turn_cmd,
  input  logic              turn_valid,
  output logic              m1_a,
  output logic              m1_b,
  output logic              m2_a,
  output logic              m2_b,
  output logic [DUTY_W-1:0] dc1,
  output logic [DUTY_W-1:0] dc2,
  output logic              node_flag,
  output logic              node_pulse,
  output logic              turn_req,
  output logic              turn_done,
  output logic              timeout_err
);

  localparam int unsigned DEB_W = 4;
  localparam int unsigned TMR_W = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FOLLOW = 3'd1;
  localparam logic [2:0] S_NODE   = 3'd2;
  localparam logic [2:0] S_TURN   = 3'd3;
  localparam logic [2:0] S_SEARCH = 3'd4;

  localparam logic [ADC_W-1:0]  TH_B    = ADC_W'(TH_BLACK);
  localparam logic [ADC_W-1:0]  TH_W    = ADC_W'(TH_WHITE);
  localparam logic [DEB_W-1:0]  DEB_MAX = DEB_W'(NODE_DEB);
  localparam logic [TMR_W-1:0]  TMR_MAX = TMR_W'(TURN_MAX);
  localparam logic [DUTY_W-1:0] DC_FWD  = DUTY_W'(DUTY_FWD);
  localparam logic [DUTY_W-1:0] DC_HI   = DUTY_W'(DUTY_HI);
  localparam logic [DUTY_W-1:0] DC_LO   = DUTY_W'(DUTY_LO);
  localparam logic [DUTY_W-1:0] DC_TURN = DUTY_W'(DUTY_TURN);
  localparam logic [DUTY_W-1:0] DC_SRCH = DUTY_W'(DUTY_SEARCH);
  localparam logic [DUTY_W-1:0] DC_OFF  = DUTY_W'(0);

  // Direction pins packed as {m1_a, m1_b, m2_a, m2_b}
  localparam logic [3:0] DIR_STOP  = 4'b0000;
  localparam logic [3:0] DIR_FWD   = 4'b1010;
  localparam logic [3:0] DIR_PIV_R = 4'b1001;
  localparam logic [3:0] DIR_PIV_L = 4'b0110;

  // Sensor classes packed as {left, middle, right}, 1 = black
  localparam logic [2:0] CLS_WBW = 3'b010;
  localparam logic [2:0] CLS_BBB = 3'b111;
  localparam logic [2:0] CLS_WWW = 3'b000;

  logic [2:0]        state_q, state_n;
  logic [2:0]        cls_q, cls_n;
  logic [DEB_W-1:0]  blk_q, blk_n;
  logic [DEB_W-1:0]  wht_q, wht_n;
  logic [TMR_W-1:0]  tmr_q, tmr_n;
  logic [1:0]        cmd_q, cmd_n;
  logic              seen_q, seen_n;
  logic [3:0]        dir_q, dir_n;
  logic [DUTY_W-1:0] dc1_n, dc2_n;
  logic              nf_n, np_n, tr_n, td_n, to_n;
  logic              all_b, all_w;

  // Grey readings keep the sensor's previous class
  function automatic logic classify(input logic [ADC_W-1:0] v, input logic prev);
    logic c;
    c = prev;
    if (v > TH_B)      c = 1'b1;
    else if (v < TH_W) c = 1'b0;
    return c;
  endfunction

  // Classes seen by this clock's decisions (current sample when valid)
  always_comb begin
    cls_n = cls_q;
    if (sample_valid) begin
      cls_n = {classify(left, cls_q[2]), classify(middle, cls_q[1]), classify(right, cls_q[0])};
    end
  end

  assign all_b = sample_valid && (cls_n == CLS_BBB);
  assign all_w = sample_valid && (cls_n == CLS_WWW);

  // State register and all registered outputs
  always_ff @(posedge clk_3125KHz or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cls_q       <= CLS_WWW;
      blk_q       <= '0;
      wht_q       <= '0;
      tmr_q       <= '0;
      cmd_q       <= 2'd0;
      seen_q      <= 1'b0;
      dir_q       <= DIR_STOP;
      dc1         <= DC_OFF;
      dc2         <= DC_OFF;
      node_flag   <= 1'b0;
      node_pulse  <= 1'b0;
      turn_req    <= 1'b0;
      turn_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_n;
      cls_q       <= cls_n;
      blk_q       <= blk_n;
      wht_q       <= wht_n;
      tmr_q       <= tmr_n;
      cmd_q       <= cmd_n;
      seen_q      <= seen_n;
      dir_q       <= dir_n;
      dc1         <= dc1_n;
      dc2         <= dc2_n;
      node_flag   <= nf_n;
      node_pulse  <= np_n;
      turn_req    <= tr_n;
      turn_done   <= td_n;
      timeout_err <= to_n;
    end
  end

  assign {m1_a, m1_b, m2_a, m2_b} = dir_q;

  // Next state, counters and next output values
  always_comb begin
    state_n = state_q;
    blk_n   = '0;
    wht_n   = '0;
    tmr_n   = '0;
    cmd_n   = cmd_q;
    seen_n  = seen_q;
    dir_n   = dir_q;
    dc1_n   = dc1;
    dc2_n   = dc2;
    np_n    = 1'b0;
    td_n    = 1'b0;
    to_n    = timeout_err;

    if (!start) begin
      state_n = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_n = S_FOLLOW;

        S_FOLLOW: begin
          blk_n = blk_q;
          wht_n = wht_q;
          if (sample_valid) begin
            blk_n = all_b ? ((blk_q == DEB_MAX) ? blk_q : blk_q + DEB_W'(1)) : '0;
            wht_n = all_w ? ((wht_q == DEB_MAX) ? wht_q : wht_q + DEB_W'(1)) : '0;
            if (all_b && (blk_n == DEB_MAX)) begin
              state_n = S_NODE;
              np_n    = 1'b1;
            end else if (all_w && (wht_n == DEB_MAX)) begin
              state_n = S_SEARCH;
            end
          end
        end

        S_NODE: begin
          if (turn_valid && turn_req) begin
            cmd_n   = turn_cmd;
            seen_n  = 1'b0;
            state_n = S_TURN;
          end
        end

        S_TURN: begin
          tmr_n = tmr_q + TMR_W'(1);
          // Turns other than straight must first leave the line they started on
          if (sample_valid && !cls_n[1]) seen_n = 1'b1;
          if (sample_valid && (cls_n == CLS_WBW) && ((cmd_q == 2'd0) || seen_q)) begin
            state_n = S_FOLLOW;
            td_n    = 1'b1;
          end else if (tmr_n == TMR_MAX) begin
            state_n = S_IDLE;
            to_n    = 1'b1;
          end
        end

        S_SEARCH: begin
          if (sample_valid && cls_n[1]) state_n = S_FOLLOW;
        end

        default: state_n = S_IDLE;
      endcase
    end

    // Motor drive reflects the state being entered
    case (state_n)
      S_FOLLOW: begin
        if (cls_n == CLS_WBW) begin
          dir_n = DIR_FWD;   dc1_n = DC_FWD; dc2_n = DC_FWD;
        end else if (cls_n[0] && !cls_n[2]) begin
          dir_n = DIR_PIV_R; dc1_n = DC_HI;  dc2_n = DC_LO;
        end else if (cls_n[2] && !cls_n[0]) begin
          dir_n = DIR_PIV_L; dc1_n = DC_LO;  dc2_n = DC_HI;
        end
      end
      S_TURN: begin
        case (cmd_n)
          2'd0:    begin dir_n = DIR_FWD;   dc1_n = DC_FWD;  dc2_n = DC_FWD;  end
          2'd3:    begin dir_n = DIR_PIV_L; dc1_n = DC_TURN; dc2_n = DC_TURN; end
          default: begin dir_n = DIR_PIV_R; dc1_n = DC_TURN; dc2_n = DC_TURN; end
        endcase
      end
      S_SEARCH: begin
        dir_n = DIR_PIV_R; dc1_n = DC_SRCH; dc2_n = DC_SRCH;
      end
      default: begin
        dir_n = DIR_STOP;  dc1_n = DC_OFF;  dc2_n = DC_OFF;
      end
    endcase

    nf_n = (state_n == S_NODE) || (state_n == S_TURN);
    tr_n = (state_n == S_NODE);
  end

endmodule
